cpc_io_master: RTL and testbench

- Synchronous Z80-style I/O bus initiator. It generates CPC expansion-port IORQ read/write cycles toward the Speak&SID decode logic at FBEE/FAEE (speech), FBDE (status) and FAC0–FADF (SID).
- Used in FPGA test hosts and bring-up rigs in place of a real CPC. A simple command port drives it: single write, single read, or status poll-until-mask-set.
- One command is in flight at a time; read data returns on a one-cycle response strobe.

---
 rtl/cpc_io_master.sv | 171 +++++++++++++++++
 tb/tb_cpc_io_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_io_master.sv
// rtl/cpc_io_master.sv - Z80-style CPC expansion-port IORQ read/write/poll initiator
module cpc_io_master #(
  parameter int WAIT_STATES = 1,
  parameter int TSTATE_CLKS = 1,
  parameter int POLL_LIMIT  = 16
) (
  input  logic        iCPC_CLOCK,
  input  logic        iRESET_N,
  input  logic        iCMD_VALID,
  input  logic        iCMD_RW,
  input  logic        iCMD_POLL,
  input  logic [15:0] iCMD_ADR,
  input  logic [7:0]  iCMD_DATA,
  output logic        oCMD_READY,
  output logic        oRSP_VALID,
  output logic [7:0]  oRSP_DATA,
  output logic        oTIMEOUT,
  output logic [15:0] oADR,
  output logic        oIORQ,
  output logic        oRD,
  output logic        oWR,
  inout  wire  [7:0]  ioCPC_DATA
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, HOLD} busStateT;

  // Terminal counts for the T-state clock divider, wait-state counter and poll counter
  localparam logic [3:0] T_LAST = 4'(TSTATE_CLKS - 1);
  localparam logic [2:0] W_LAST = 3'(WAIT_STATES - 1);
  localparam logic [7:0] P_LAST = 8'(POLL_LIMIT);

  busStateT    state;
  busStateT    nextState;
  logic [3:0]  tCnt;
  logic [2:0]  wCnt;
  logic [7:0]  pollCnt;
  logic        latRw;
  logic        latPoll;
  logic [15:0] latAdr;
  logic [7:0]  latData;
  logic [7:0]  rspData;

  logic        accept;
  logic        tLast;
  logic        pollHit;
  logic        pollOut;
  logic        pollDone;
  logic        dataDrive;

  assign accept  = iCMD_VALID && (state == IDLE);
  assign tLast   = (tCnt == T_LAST);
  // The sample captured at the end of T3 is what the mask is tested against in HOLD
  assign pollHit = (rspData & latData) != 8'h00;
  assign pollOut = (pollCnt >= P_LAST);
  assign pollDone = !latPoll || pollHit || pollOut;

  assign oADR      = latAdr;
  assign oRSP_DATA = rspData;
  assign ioCPC_DATA = dataDrive ? latData : 8'hzz;

  // State register, command latch, T-state/wait/poll counters and read capture
  always_ff @(posedge iCPC_CLOCK) begin
    if (!iRESET_N) begin
      state   <= IDLE;
      tCnt    <= 4'd0;
      wCnt    <= 3'd0;
      pollCnt <= 8'd0;
      latRw   <= 1'b0;
      latPoll <= 1'b0;
      latAdr  <= 16'h0000;
      latData <= 8'h00;
      rspData <= 8'h00;
    end else begin
      state <= nextState;

      if (accept) begin
        latRw   <= iCMD_RW;
        latPoll <= iCMD_RW && iCMD_POLL;
        latAdr  <= iCMD_ADR;
        latData <= iCMD_DATA;
        pollCnt <= 8'd0;
      end

      if ((state inside {T1, T2, TW, T3}) && !tLast) begin
        tCnt <= tCnt + 4'd1;
      end else begin
        tCnt <= 4'd0;
      end

      if (state == TW) begin
        if (tLast) begin
          wCnt <= wCnt + 3'd1;
        end
      end else begin
        wCnt <= 3'd0;
      end

      if ((state == T3) && tLast) begin
        if (latRw) begin
          rspData <= ioCPC_DATA;
          pollCnt <= pollCnt + 8'd1;
        end
      end
    end
  end

  // Next-state sequencing and bus strobe/response decode
  always_comb begin
    nextState  = state;
    oCMD_READY = 1'b0;
    oIORQ      = 1'b1;
    oRD        = 1'b1;
    oWR        = 1'b1;
    oRSP_VALID = 1'b0;
    oTIMEOUT   = 1'b0;
    dataDrive  = 1'b0;

    case (state)
      IDLE: begin
        oCMD_READY = 1'b1;
        if (iCMD_VALID) begin
          nextState = T1;
        end
      end
      T1: begin
        dataDrive = !latRw;
        if (tLast) begin
          nextState = T2;
        end
      end
      T2: begin
        dataDrive = !latRw;
        oIORQ     = 1'b0;
        oRD       = !latRw;
        oWR       = latRw;
        if (tLast) begin
          nextState = (WAIT_STATES == 0) ? T3 : TW;
        end
      end
      TW: begin
        dataDrive = !latRw;
        oIORQ     = 1'b0;
        oRD       = !latRw;
        oWR       = latRw;
        if (tLast && (wCnt == W_LAST)) begin
          nextState = T3;
        end
      end
      T3: begin
        dataDrive = !latRw;
        oIORQ     = 1'b0;
        oRD       = !latRw;
        oWR       = latRw;
        if (tLast) begin
          nextState = HOLD;
        end
      end
      HOLD: begin
        dataDrive  = !latRw;
        oRSP_VALID = latRw && pollDone;
        oTIMEOUT   = latPoll && !pollHit && pollOut;
        // An unsatisfied poll under its limit re-enters T1 with no IDLE gap
        nextState  = pollDone ? IDLE : T1;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpc_io_master.sv
// tb/tb_cpc_io_master.sv - randomized scoreboard bench for cpc_io_master at two timing configurations
module tb_cpc_io_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int doneCnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic markDone();
    doneCnt++;
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int WS = (g == 0) ? 1 : 3;
    localparam int TS = (g == 0) ? 1 : 2;
    localparam int PL = (g == 0) ? 4 : 3;
    localparam int L  = TS * (3 + WS) + 1;

    logic        resetN;
    logic        cmdValid;
    logic        cmdRw;
    logic        cmdPoll;
    logic [15:0] cmdAdr;
    logic [7:0]  cmdData;
    logic        cmdReady;
    logic        rspValid;
    logic [7:0]  rspData;
    logic        timeout;
    logic [15:0] adr;
    logic        iorqN;
    logic        rdN;
    logic        wrN;
    wire  [7:0]  bus;

    logic        wrActive;
    logic [7:0]  curByte;
    logic [7:0]  rdBytes [8];
    logic [8:0]  expQ [$];
    logic [8:0]  monExp;
    logic [7:0]  lastRsp;

    // Bus slave: answers reads with curByte; otherwise holds 0x00 unless a write owns the bus
    assign bus = !rdN ? curByte : (wrActive ? 8'hzz : 8'h00);

    cpc_io_master #(.WAIT_STATES(WS), .TSTATE_CLKS(TS), .POLL_LIMIT(PL)) dut (
      .iCPC_CLOCK(clk),
      .iRESET_N(resetN),
      .iCMD_VALID(cmdValid),
      .iCMD_RW(cmdRw),
      .iCMD_POLL(cmdPoll),
      .iCMD_ADR(cmdAdr),
      .iCMD_DATA(cmdData),
      .oCMD_READY(cmdReady),
      .oRSP_VALID(rspValid),
      .oRSP_DATA(rspData),
      .oTIMEOUT(timeout),
      .oADR(adr),
      .oIORQ(iorqN),
      .oRD(rdN),
      .oWR(wrN),
      .ioCPC_DATA(bus)
    );

    // Response monitor: every pulse must match the oldest expected response
    always @(negedge clk) begin
      if (resetN && rspValid) begin
        if (expQ.size() == 0) begin
          check($sformatf("i%0d rsp_unexpected", g), 32'(rspValid), 32'd0);
        end else begin
          monExp = expQ.pop_front();
          check($sformatf("i%0d rsp_data", g), 32'(rspData), 32'(monExp[7:0]));
          check($sformatf("i%0d rsp_timeout", g), 32'(timeout), 32'(monExp[8]));
        end
      end
    end

    task automatic scramble();
      cmdValid = 1'($urandom);
      cmdRw    = 1'($urandom);
      cmdPoll  = 1'($urandom);
      cmdAdr   = 16'($urandom);
      cmdData  = 8'($urandom);
    endtask

    task automatic runCmd(input logic rw, input logic poll, input logic [15:0] a, input logic [7:0] d);
      int   nIt;
      logic isPoll;
      logic [7:0] last;
      logic tmo;
      logic low;
      logic expRsp;
      isPoll = rw & poll;
      nIt = isPoll ? PL : 1;
      if (isPoll) begin
        for (int i = 0; i < PL; i++) begin
          if ((rdBytes[i] & d) != 8'h00) begin
            nIt = i + 1;
            break;
          end
        end
      end
      last = rdBytes[nIt - 1];
      tmo  = isPoll && ((last & d) == 8'h00);
      if (rw) expQ.push_back({tmo, last});

      check($sformatf("i%0d idle_strobes", g), 32'({cmdReady, iorqN, rdN, wrN}), 32'hF);
      check($sformatf("i%0d rsp_hold", g), 32'(rspData), 32'(lastRsp));
      check($sformatf("i%0d bus_idle", g), 32'(bus), 32'h00);

      cmdValid = 1'b1; cmdRw = rw; cmdPoll = poll; cmdAdr = a; cmdData = d;
      curByte = rdBytes[0];
      @(posedge clk);
      wrActive = !rw;
      #1;
      scramble();
      for (int it = 0; it < nIt; it++) begin
        curByte = rdBytes[it];
        for (int o = 1; o <= L; o++) begin
          @(negedge clk);
          low    = (o > TS) && (o < L);
          expRsp = rw && (it == nIt - 1) && (o == L);
          check($sformatf("i%0d strobes it=%0d o=%0d", g, it, o),
                32'({cmdReady, iorqN, rdN, wrN, rspValid, timeout}),
                32'({1'b0, !low, !(low && rw), !(low && !rw), expRsp, expRsp && tmo}));
          check($sformatf("i%0d adr o=%0d", g, o), 32'(adr), 32'(a));
          if (!rw) check($sformatf("i%0d wdata o=%0d", g, o), 32'(bus), 32'(d));
          scramble();
        end
      end
      cmdValid = 1'b0;
      if (rw) lastRsp = last;
      @(posedge clk);
      wrActive = 1'b0;
      @(negedge clk);
    endtask

    task automatic resetMidWrite();
      cmdValid = 1'b1; cmdRw = 1'b0; cmdPoll = 1'b0; cmdAdr = 16'hFBEE; cmdData = 8'hC3;
      @(posedge clk);
      wrActive = 1'b1;
      #1 cmdValid = 1'b0;
      repeat (2 * TS) @(negedge clk);
      @(negedge clk);
      check($sformatf("i%0d tw_write", g), 32'({iorqN, wrN, bus}), 32'({1'b0, 1'b0, 8'hC3}));
      resetN = 1'b0;
      @(posedge clk);
      wrActive = 1'b0;
      @(negedge clk);
      check($sformatf("i%0d reset_abort", g),
            32'({cmdReady, iorqN, rdN, wrN, rspValid, timeout}), 32'b111100);
      check($sformatf("i%0d reset_bus", g), 32'(bus), 32'h00);
      check($sformatf("i%0d reset_adr", g), 32'(adr), 32'h0000);
      lastRsp = 8'h00;
      resetN = 1'b1;
    endtask

    // Directed test-plan cases, mid-write reset, then randomized commands
    initial begin
      resetN = 1'b0; cmdValid = 1'b0; cmdRw = 1'b0; cmdPoll = 1'b0;
      cmdAdr = 16'h0; cmdData = 8'h0; wrActive = 1'b0; curByte = 8'h00; lastRsp = 8'h00;
      for (int i = 0; i < 8; i++) rdBytes[i] = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("i%0d reset_state", g),
            32'({cmdReady, iorqN, rdN, wrN, rspValid, timeout}), 32'b111100);
      check($sformatf("i%0d reset_adr0", g), 32'(adr), 32'h0000);
      check($sformatf("i%0d reset_rsp", g), 32'(rspData), 32'h00);
      check($sformatf("i%0d reset_bus0", g), 32'(bus), 32'h00);
      resetN = 1'b1;

      runCmd(1'b0, 1'b0, 16'hFBEE, 8'h55);
      rdBytes[0] = 8'hA3;
      runCmd(1'b1, 1'b0, 16'hFAEE, 8'h00);
      rdBytes[0] = 8'h00; rdBytes[1] = 8'h00; rdBytes[2] = 8'h01;
      runCmd(1'b1, 1'b1, 16'hFBDE, 8'h01);
      for (int i = 0; i < 8; i++) rdBytes[i] = 8'h00;
      runCmd(1'b1, 1'b1, 16'hFBDE, 8'h01);
      for (int i = 0; i < 8; i++) rdBytes[i] = 8'hFF;
      runCmd(1'b1, 1'b1, 16'hFBDE, 8'h00);
      runCmd(1'b0, 1'b1, 16'hFAC5, 8'h3C);
      resetMidWrite();
      runCmd(1'b0, 1'b0, 16'hFAEE, 8'h96);

      for (int n = 0; n < 40; n++) begin
        logic rw;
        logic poll;
        logic [15:0] a;
        logic [7:0] d;
        rw   = 1'($urandom);
        poll = 1'($urandom);
        case ($urandom_range(0, 3))
          0: a = 16'hFBEE;
          1: a = 16'hFAEE;
          2: a = 16'hFBDE;
          default: a = 16'hFAC0 + 16'($urandom_range(0, 31));
        endcase
        d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        for (int i = 0; i < PL; i++) rdBytes[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        runCmd(rw, poll, a, d);
      end

      check($sformatf("i%0d leftover_rsp", g), 32'(expQ.size()), 32'd0);
      markDone();
    end
  end

  // Wait for both instances with a cycle bound, then report
  initial begin
    int cyc;
    cyc = 0;
    while (doneCnt < 2 && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (doneCnt < 2) check("run_timeout", 32'(doneCnt), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
